// File: rtl/exec_fwd_scoreboard.sv
// Execute-stage forwarding and load-use hazard controller.
// Tracks post-execute register writers in a shadow pipeline and picks a forwarding source per operand.
module exec_fwd_scoreboard #(
   parameter int NUM_SRC         = 3,
   parameter int NUM_FWD         = 2,
   parameter int REG_W           = 4,
   parameter int LOAD_READY_SLOT = 1,
   parameter int PC_REG          = 15,
   parameter int SEL_W           = $clog2(NUM_FWD + 1),
   parameter int CNT_W           = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ex_valid,
   input  logic                     ex_wr_en,
   input  logic [REG_W-1:0]         ex_wr_reg,
   input  logic                     ex_is_load,
   input  logic                     ex_flush,
   input  logic [NUM_SRC-1:0]       src_used,
   input  logic [NUM_SRC*REG_W-1:0] src_reg,
   output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
   output logic                     stall,
   output logic [NUM_FWD-1:0]       slot_valid,
   output logic [CNT_W-1:0]         stall_cycles
);

   localparam logic [REG_W-1:0] PC_IDX  = REG_W'(PC_REG);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NUM_FWD-1:0]             slot_valid_q, slot_valid_d;
   logic [NUM_FWD-1:0]             slot_load_q, slot_load_d;
   logic [NUM_FWD-1:0][REG_W-1:0]  slot_reg_q, slot_reg_d;
   logic [NUM_FWD-1:0]             slot_ready_s;
   logic [CNT_W-1:0]               stall_cnt_q, stall_cnt_d;
   logic [NUM_SRC*SEL_W-1:0]       fwd_sel_s;
   logic                           stall_s;

   // Load data only becomes forwardable once it reaches LOAD_READY_SLOT
   always_comb begin
      for (int k = 0; k < NUM_FWD; k++) begin
         if (k >= LOAD_READY_SLOT) begin
            slot_ready_s[k] = 1'b1;
         end else begin
            slot_ready_s[k] = ~slot_load_q[k];
         end
      end
   end

   // Per-operand youngest-match search; an unready youngest match blocks issue
   always_comb begin
      logic                 hit;
      logic                 match;
      logic                 win_ready;
      logic                 blocked;
      logic [SEL_W-1:0]     win;
      logic [REG_W-1:0]     opnd;
      fwd_sel_s = '0;
      blocked   = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         opnd      = src_reg[i*REG_W +: REG_W];
         hit       = 1'b0;
         win       = '0;
         win_ready = 1'b0;
         for (int k = NUM_FWD - 1; k >= 0; k--) begin
            match     = src_used[i] & slot_valid_q[k] & (slot_reg_q[k] == opnd) & (opnd != PC_IDX);
            win       = match ? SEL_W'(k + 1) : win;
            win_ready = match ? slot_ready_s[k] : win_ready;
            hit       = hit | match;
         end
         if (hit && win_ready) begin
            fwd_sel_s[i*SEL_W +: SEL_W] = win;
         end else begin
            fwd_sel_s[i*SEL_W +: SEL_W] = '0;
         end
         blocked = blocked | (hit & ~win_ready);
      end
      stall_s = ex_valid & ~ex_flush & blocked;
   end

   // Shadow pipeline advance and saturating stall counter
   always_comb begin
      slot_valid_d[0] = ex_valid & ex_wr_en & ~stall_s & ~ex_flush;
      slot_reg_d[0]   = ex_wr_reg;
      slot_load_d[0]  = ex_is_load;
      for (int k = 1; k < NUM_FWD; k++) begin
         slot_valid_d[k] = slot_valid_q[k-1];
         slot_reg_d[k]   = slot_reg_q[k-1];
         slot_load_d[k]  = slot_load_q[k-1];
      end
      if (stall_s && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_valid_q <= '0;
         slot_reg_q   <= '0;
         slot_load_q  <= '0;
         stall_cnt_q  <= '0;
      end else begin
         slot_valid_q <= slot_valid_d;
         slot_reg_q   <= slot_reg_d;
         slot_load_q  <= slot_load_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign fwd_sel      = fwd_sel_s;
   assign stall        = stall_s;
   assign slot_valid   = slot_valid_q;
   assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_exec_fwd_scoreboard.sv
// Bench for exec_fwd_scoreboard: directed instruction sequences, an age-based writer history model,
// and a second instance with a 4-bit counter for saturation.
module tb_exec_fwd_scoreboard;

   localparam int NS  = 3;
   localparam int NF  = 2;
   localparam int RW  = 4;
   localparam int SW  = 2;
   localparam int LRS = 1;
   localparam int PC  = 15;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ex_valid = 1'b0, ex_wr_en = 1'b0, ex_is_load = 1'b0, ex_flush = 1'b0;
   logic [RW-1:0]    ex_wr_reg = '0;
   logic [NS-1:0]    src_used = '0;
   logic [NS*RW-1:0] src_reg = '0;

   logic [NS*SW-1:0] fwd_sel, fwd_sel4;
   logic             stall, stall4;
   logic [NF-1:0]    slot_valid, slot_valid4;
   logic [15:0]      stall_cycles;
   logic [3:0]       stall_cycles4;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   exec_fwd_scoreboard dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_wr_en(ex_wr_en), .ex_wr_reg(ex_wr_reg),
      .ex_is_load(ex_is_load), .ex_flush(ex_flush), .src_used(src_used), .src_reg(src_reg),
      .fwd_sel(fwd_sel), .stall(stall), .slot_valid(slot_valid), .stall_cycles(stall_cycles)
   );

   exec_fwd_scoreboard #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_wr_en(ex_wr_en), .ex_wr_reg(ex_wr_reg),
      .ex_is_load(ex_is_load), .ex_flush(ex_flush), .src_used(src_used), .src_reg(src_reg),
      .fwd_sel(fwd_sel4), .stall(stall4), .slot_valid(slot_valid4), .stall_cycles(stall_cycles4)
   );

   // Model: writer history indexed by age (0 = issued last cycle), plus a raw stall tally.
   bit          m_v [NF];
   bit          m_l [NF];
   logic [RW-1:0] m_r [NF];
   int          m_stalls = 0;

   function automatic int win_age(int i);
      logic [RW-1:0] r = src_reg[i*RW +: RW];
      if (!src_used[i] || r == RW'(PC)) return -1;
      for (int age = 0; age < NF; age++)
         if (m_v[age] && m_r[age] == r) return age;
      return -1;
   endfunction

   function automatic bit age_ready(int age);
      return !m_l[age] || age >= LRS;
   endfunction

   function automatic logic [NS*SW-1:0] exp_sel();
      logic [NS*SW-1:0] s = '0;
      for (int i = 0; i < NS; i++) begin
         int a;
         a = win_age(i);
         if (a >= 0 && age_ready(a)) s[i*SW +: SW] = SW'(a + 1);
      end
      return s;
   endfunction

   function automatic bit exp_stall();
      bit blocked = 1'b0;
      for (int i = 0; i < NS; i++) begin
         int a;
         a = win_age(i);
         if (a >= 0 && !age_ready(a)) blocked = 1'b1;
      end
      return ex_valid && !ex_flush && blocked;
   endfunction

   function automatic logic [NF-1:0] exp_slots();
      logic [NF-1:0] v;
      for (int k = 0; k < NF; k++) v[k] = m_v[k];
      return v;
   endfunction

   function automatic int sat(int n, int max);
      return (n > max) ? max : n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NF; k++) begin
            m_v[k] <= 1'b0;
            m_l[k] <= 1'b0;
            m_r[k] <= '0;
         end
         m_stalls <= 0;
      end else begin
         m_v[0] <= ex_valid && ex_wr_en && !exp_stall() && !ex_flush;
         m_r[0] <= ex_wr_reg;
         m_l[0] <= ex_is_load;
         for (int k = 1; k < NF; k++) begin
            m_v[k] <= m_v[k-1];
            m_r[k] <= m_r[k-1];
            m_l[k] <= m_l[k-1];
         end
         if (exp_stall()) m_stalls <= m_stalls + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      chk("fwd_sel",       32'(fwd_sel),       32'(exp_sel()));
      chk("fwd_sel_c4",    32'(fwd_sel4),      32'(exp_sel()));
      chk("stall",         32'(stall),         32'(exp_stall()));
      chk("stall_c4",      32'(stall4),        32'(exp_stall()));
      chk("slot_valid",    32'(slot_valid),    32'(exp_slots()));
      chk("slot_valid_c4", 32'(slot_valid4),   32'(exp_slots()));
      chk("stall_cycles",  32'(stall_cycles),  32'(sat(m_stalls, 65535)));
      chk("stall_cyc_c4",  32'(stall_cycles4), 32'(sat(m_stalls, 15)));
   end

   // One execute-stage instruction per call; returns with outputs settled
   task automatic cyc(input bit v, input bit we, input int wr, input bit ld, input bit fl,
                      input bit [2:0] used, input int a, input int b, input int c);
      @(posedge clk);
      #1;
      ex_valid   = v;
      ex_wr_en   = we;
      ex_wr_reg  = RW'(wr);
      ex_is_load = ld;
      ex_flush   = fl;
      src_used   = used;
      src_reg    = {RW'(c), RW'(b), RW'(a)};
      @(negedge clk);
      #1;
   endtask

   task automatic nop();
      cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 3'b000, 0, 0, 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #1;
      chk("reset_slots", 32'(slot_valid), 32'd0);
      chk("reset_count", 32'(stall_cycles), 32'd0);
      chk("reset_fwd",   32'(fwd_sel), 32'd0);
      chk("reset_stall", 32'(stall), 32'd0);
      rst_n = 1'b1;

      // ADD r1 ; SUB r2,r1,r3 ; reader of r1
      cyc(1, 1, 1, 0, 0, 3'b000, 0, 0, 0);
      cyc(1, 1, 2, 0, 0, 3'b011, 1, 3, 0);
      chk("alu_fwd_slot0", 32'(fwd_sel), 32'h01);
      chk("alu_no_stall",  32'(stall), 32'd0);
      cyc(1, 0, 0, 0, 0, 3'b001, 1, 0, 0);
      chk("alu_fwd_slot1", 32'(fwd_sel), 32'h02);
      nop(); nop();

      // LDR r4 ; ADD r5,r4,r4 (held one cycle)
      cyc(1, 1, 4, 1, 0, 3'b000, 0, 0, 0);
      cyc(1, 1, 5, 0, 0, 3'b011, 4, 4, 0);
      chk("lu_stall",      32'(stall), 32'd1);
      chk("lu_fwd_none",   32'(fwd_sel), 32'd0);
      chk("lu_count0",     32'(stall_cycles), 32'd0);
      cyc(1, 1, 5, 0, 0, 3'b011, 4, 4, 0);
      chk("lu_released",   32'(stall), 32'd0);
      chk("lu_fwd_dup",    32'(fwd_sel), 32'h0A);
      chk("lu_count1",     32'(stall_cycles), 32'd1);
      chk("lu_bubble",     32'(slot_valid), 32'd2);
      nop(); nop();

      // ADD r1 ; ADD r1 ; reader of r1 -> youngest wins
      cyc(1, 1, 1, 0, 0, 3'b000, 0, 0, 0);
      cyc(1, 1, 1, 0, 0, 3'b000, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 3'b001, 1, 0, 0);
      chk("youngest_wins", 32'(fwd_sel), 32'h01);
      nop(); nop();

      // PC never forwarded; flushed writer never enters a slot
      cyc(1, 1, 15, 0, 0, 3'b000, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 3'b111, 15, 15, 15);
      chk("pc_no_fwd",   32'(fwd_sel), 32'd0);
      chk("pc_no_stall", 32'(stall), 32'd0);
      cyc(1, 1, 6, 0, 1, 3'b000, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 3'b001, 6, 0, 0);
      chk("flush_slot0", 32'(slot_valid), 32'd0);
      chk("flush_nofwd", 32'(fwd_sel), 32'd0);
      nop(); nop();

      // Flushed consumer of an unready load never stalls
      cyc(1, 1, 2, 1, 0, 3'b000, 0, 0, 0);
      cyc(1, 1, 7, 0, 1, 3'b001, 2, 0, 0);
      chk("flush_over_stall", 32'(stall), 32'd0);
      nop();
      chk("flush_bubble", 32'(slot_valid), 32'd2);

      // ex_valid = 0 writer is a bubble
      cyc(0, 1, 8, 0, 0, 3'b000, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 3'b001, 8, 0, 0);
      chk("invalid_nofwd", 32'(fwd_sel), 32'd0);

      // Back-to-back dependent loads: every other cycle stalls, 20 stalls in 40
      for (int n = 0; n < 40; n++) cyc(1, 1, 9, 1, 0, 3'b001, 9, 0, 0);
      nop();
      chk("count_total", 32'(stall_cycles), 32'd21);
      chk("count_sat4",  32'(stall_cycles4), 32'd15);

      // Asynchronous reset with both slots occupied
      cyc(1, 1, 1, 0, 0, 3'b000, 0, 0, 0);
      cyc(1, 1, 2, 0, 0, 3'b000, 0, 0, 0);
      nop();
      chk("slots_full", 32'(slot_valid), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_slots", 32'(slot_valid), 32'd0);
      chk("async_rst_count", 32'(stall_cycles), 32'd0);
      chk("async_rst_cnt4",  32'(stall_cycles4), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1, 0, 0, 0, 0, 3'b011, 1, 2, 0);
      chk("post_rst_nofwd", 32'(fwd_sel), 32'd0);
      nop();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/exec_fwd_scoreboard.md
Name: exec_fwd_scoreboard

Overview:
- Parametrised forwarding and hazard controller for the execute stage; next generation of the fixed 3-operand execute forwarding logic.
- Tracks in-flight register writers in a NUM_FWD-deep shadow pipeline that mirrors the stages after execute.
- Per source operand, selects the youngest valid forwarding slot or the register file.
- Raises a load-use stall when the matching writer's data is not yet available, and counts stall cycles.

Parameters:
NUM_SRC, 3, number of source operands checked per execute instruction (Rn, Rm, Rs)
NUM_FWD, 2, number of tracked post-execute slots (slot 0 = memory, slot 1 = writeback)
REG_W, 4, register index width
LOAD_READY_SLOT, 1, first slot index at which load data is forwardable
PC_REG, 15, register index never forwarded and never stalled on
SEL_W, $clog2(NUM_FWD+1), fwd_sel field width
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  execute stage holds a real instruction (not NOP)
ex_wr_en  in  1  execute instruction writes a register
ex_wr_reg  in  REG_W  its destination register (Rd, or Rt for loads, or Rn for pre-indexed writeback)
ex_is_load  in  1  execute instruction is LDR/LDR_Lit
ex_flush  in  1  branch taken: execute instruction is squashed
src_used  in  NUM_SRC  per-operand "instruction reads this source"
src_reg  in  NUM_SRC*REG_W  packed source indices, operand i at [i*REG_W +: REG_W]
fwd_sel  out  NUM_SRC*SEL_W  per operand: 0 = regfile, k+1 = forward from slot k
stall  out  1  hold fetch/decode/execute, inject bubble into slot 0
slot_valid  out  NUM_FWD  debug: slot occupancy
stall_cycles  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset: clk and rst_n only; reset is asynchronous and active-low. All slots invalid; stall_cycles = 0. fwd_sel = 0 and stall = 0 follow combinationally from the cleared slots.
- Slot fields: valid, reg, is_load, age (index). Each slot's ready = !is_load || (index >= LOAD_READY_SLOT).
- Shift (every clock edge, no enable):
  - Slot k+1 <= slot k.
  - Slot NUM_FWD-1 retires.
  - Slot 0 <= {ex_valid & ex_wr_en & !stall & !ex_flush, ex_wr_reg, ex_is_load}.
  - Stall or flush therefore inserts a bubble (valid = 0) into slot 0 while older slots still advance.
- Match: operand i matches slot k if src_used[i] && slot k valid && slot k reg == src_reg[i] && src_reg[i] != PC_REG.
- Priority: the lowest k (youngest) among matches wins; older matches are ignored.
- fwd_sel[i] (combinational, same cycle):
  - = winning k+1 if a match exists and that slot is ready.
  - = 0 otherwise, including no match.
- stall (combinational): = ex_valid && !ex_flush && any operand whose winning slot is not ready.
  - An older ready match never masks a younger unready one.
- Load-use latency: with the default parameters, a load immediately followed by a consumer stalls exactly 1 cycle. The next cycle the load sits in slot 1 and fwd_sel = 2.
- ex_flush has priority over stall: a flushed instruction never stalls and never enters a slot.
- stall_cycles: increments on each clock where stall = 1; saturates at all-ones.
- Reset mid-operation: all slots are cleared immediately. No forwarding occurs from pre-reset writers.
- ex_wr_en = 0 or ex_valid = 0 (stores, compares, NOPs) produces a bubble slot.
- Duplicate operands reading the same register each resolve independently and identically.

Test Plan:
- ADD r1 issued, then SUB r2,r1,r3 next cycle -> cycle 2: fwd_sel[0] = 1, stall = 0. Following cycle, consumer of r1 gets fwd_sel = 2.
- LDR r4 then ADD r5,r4,r4 -> stall = 1 for exactly 1 cycle, slot 0 bubble, stall_cycles 0->1. Next cycle fwd_sel[0] = fwd_sel[1] = 2, stall = 0.
- ADD r1 then ADD r1 then consumer of r1 -> consumer selects slot 0 (fwd_sel = 1), not slot 1.
- Writer to r15 followed by reader of r15 -> fwd_sel = 0, stall = 0. Writer with ex_flush = 1 -> slot_valid[0] = 0 next cycle, no forwarding.
- LDR r2 in slot 0 with ex_flush = 1 and a consumer of r2 in execute -> stall = 0. Separately assert rst_n = 0 with slots full -> slot_valid = 0, stall_cycles = 0 immediately.
- Force 2^CNT_W+3 stalled cycles (CNT_W overridden to 4, 19 cycles) -> stall_cycles holds at 15.
